bram_byte_loader: RTL and testbench

- Upstream write stage for the dual-port byte-write-enable feature/weight BRAM.
- Accepts an 8-bit valid/ready byte stream (pixels or int8 weights from the DMA/PS side).
- Writes each accepted byte into its lane of a MEM_WIDTH-bit word, using one-hot byte write enables. No read-modify-write is needed.
- Counts bytes from a programmed base word address, handles early termination and address wrap, and reports completion to the layer controller.

---
 rtl/bram_byte_loader_pkg.sv | 12 +
 rtl/bram_lane_addr_gen.sv | 30 +++
 rtl/bram_byte_loader.sv | 107 ++++++++++
 tb/tb_bram_byte_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_byte_loader_pkg.sv
// Shared constants for the BRAM byte loader: lane width and FSM encodings.
package bram_byte_loader_pkg;
  localparam int COL_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int num_col(input int mem_width);
    return mem_width / COL_WIDTH;
  endfunction
endpackage

// File: rtl/bram_lane_addr_gen.sv
// Maps a running byte index onto a one-hot lane and a wrapped BRAM word address.
module bram_lane_addr_gen
  import bram_byte_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_DEPTH  = 512,
  parameter int LEN_WIDTH  = 11
) (
  input  logic [ADDR_WIDTH-1:0]             base,
  input  logic [LEN_WIDTH-1:0]              byte_idx,
  output logic [num_col(MEM_WIDTH)-1:0]     lane_oh,
  output logic [ADDR_WIDTH-1:0]             word_addr
);
  localparam int NUM_COL = num_col(MEM_WIDTH);
  localparam int SW = ((LEN_WIDTH > ADDR_WIDTH) ? LEN_WIDTH : ADDR_WIDTH) + 1;

  logic [LEN_WIDTH-1:0] lane_idx;
  logic [SW-1:0]        sum;

  assign lane_idx = byte_idx % LEN_WIDTH'(NUM_COL);

  for (genvar i = 0; i < NUM_COL; i++) begin : g_lane
    assign lane_oh[i] = (lane_idx == LEN_WIDTH'(i));
  end

  // Modulo keeps the wrap correct even when MEM_DEPTH is not a power of two.
  assign sum       = SW'(base) + SW'(byte_idx / LEN_WIDTH'(NUM_COL));
  assign word_addr = ADDR_WIDTH'(sum % SW'(MEM_DEPTH));
endmodule

// File: rtl/bram_byte_loader.sv
// Byte-stream to BRAM write stage: one byte per handshake into its lane via byte write enables.
module bram_byte_loader
  import bram_byte_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_DEPTH  = 512,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base_addr,
  input  logic [LEN_WIDTH-1:0]        i_num_byte,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [7:0]                  s_data,
  input  logic                        s_last,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_short,
  output logic [LEN_WIDTH-1:0]        o_byte_cnt,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  output logic                        bram_ce,
  output logic [MEM_WIDTH/8-1:0]      bram_we,
  output logic [MEM_WIDTH-1:0]        bram_d
);
  localparam int NUM_COL = num_col(MEM_WIDTH);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  num_q;
  logic [LEN_WIDTH-1:0]  byte_idx;
  logic [LEN_WIDTH-1:0]  idx_nxt;
  logic                  short_q;
  logic                  hs;
  logic [NUM_COL-1:0]    lane_oh;
  logic [ADDR_WIDTH-1:0] word_addr;

  bram_lane_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_WIDTH(MEM_WIDTH),
    .MEM_DEPTH(MEM_DEPTH),   .LEN_WIDTH(LEN_WIDTH)
  ) u_addr_gen (
    .base     (base_q),
    .byte_idx (byte_idx),
    .lane_oh  (lane_oh),
    .word_addr(word_addr)
  );

  assign s_ready = (state == ST_RUN);
  assign o_busy  = (state == ST_RUN) || (state == ST_DONE);
  assign o_done  = (state == ST_DONE);
  assign o_short = short_q && (state == ST_DONE);
  assign hs      = s_valid && s_ready;
  assign idx_nxt = byte_idx + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      byte_idx   <= '0;
      short_q    <= 1'b0;
      o_byte_cnt <= '0;
      bram_addr  <= '0;
      bram_ce    <= 1'b0;
      bram_we    <= '0;
      bram_d     <= '0;
    end else begin
      // Strobes are single-cycle; data/address simply hold between writes.
      bram_ce <= 1'b0;
      bram_we <= '0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            base_q     <= i_base_addr;
            num_q      <= i_num_byte;
            byte_idx   <= '0;
            o_byte_cnt <= '0;
            short_q    <= 1'b0;
            state      <= (i_num_byte == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs) begin
            bram_ce    <= 1'b1;
            bram_we    <= lane_oh;
            bram_addr  <= word_addr;
            bram_d     <= {NUM_COL{s_data}};
            byte_idx   <= idx_nxt;
            o_byte_cnt <= idx_nxt;
            // Reaching the count wins over s_last, so a coincident last is not short.
            if (idx_nxt == num_q) begin
              state   <= ST_DONE;
              short_q <= 1'b0;
            end else if (s_last) begin
              state   <= ST_DONE;
              short_q <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_byte_loader.sv
// Directed bench for bram_byte_loader with a behavioural BRAM capturing the write port.
module tb_bram_byte_loader;
  logic        clk, reset;
  logic        i_start;
  logic [8:0]  i_base_addr;
  logic [10:0] i_num_byte;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        o_busy, o_done, o_short;
  logic [10:0] o_byte_cnt;
  logic [8:0]  bram_addr;
  logic        bram_ce;
  logic [3:0]  bram_we;
  logic [31:0] bram_d;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int multi_we = 0;
  logic [31:0] mem [0:511];

  bram_byte_loader dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_byte(i_num_byte), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .o_busy(o_busy), .o_done(o_done), .o_short(o_short),
    .o_byte_cnt(o_byte_cnt), .bram_addr(bram_addr), .bram_ce(bram_ce),
    .bram_we(bram_we), .bram_d(bram_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_ce) begin
      wr_count++;
      if ($countones(bram_we) > 1) multi_we++;
      for (int k = 0; k < 4; k++)
        if (bram_we[k]) mem[bram_addr][8*k +: 8] = bram_d[8*k +: 8];
    end
  end

  task automatic start_load(input logic [8:0] b, input logic [10:0] n);
    i_start = 1'b1; i_base_addr = b; i_num_byte = n;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] outs;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    outs = {s_ready, o_busy, o_done, o_short, o_byte_cnt, bram_addr, bram_ce, bram_we, bram_d};
    checks++;
    if (outs !== 64'd0) begin
      errors++; $display("FAIL reset_outs: got %h expected 0", outs);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [45:0] got, exp;
    wr_count = 0;
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'hFFFF_FFFF;
    start_load(9'd0, 11'd8);
    checks++;
    if (s_ready !== 1'b1 || o_busy !== 1'b1) begin
      errors++; $display("FAIL basic_run_entry: ready=%b busy=%b expected 1 1", s_ready, o_busy);
    end
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 1);
      @(negedge clk);
      got = {bram_ce, bram_we, bram_addr, bram_d};
      exp = {1'b1, 4'(1 << (i % 4)), 9'(i / 4), {4{8'(i + 1)}}};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL basic_write%0d: got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (o_done !== 1'b1 || o_byte_cnt !== 11'd8 || o_short !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b cnt=%0d short=%b ready=%b expected 1 8 0 0",
               o_done, o_byte_cnt, o_short, s_ready);
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: done=%b busy=%b expected 0 0", o_done, o_busy);
    end
    checks++;
    if (mem[0] !== 32'h0403_0201 || mem[1] !== 32'h0807_0605) begin
      errors++; $display("FAIL basic_readback: got %h %h expected 04030201 08070605", mem[0], mem[1]);
    end
  endtask

  task automatic test_bubbles;
    logic [9:0] pat;
    int k;
    pat = 10'b1011001101;
    k = 0;
    mem[5] = 32'h0; mem[6] = 32'hAABB_CCDD;
    start_load(9'd5, 11'd6);
    wr_count = 0;
    for (int c = 0; c < 10; c++) begin
      s_valid = pat[c]; s_data = 8'(8'h10 + k);
      @(negedge clk);
      checks++;
      if (pat[c]) begin
        if (bram_ce !== 1'b1 || bram_we !== 4'(1 << (k % 4)) || bram_addr !== 9'(5 + k / 4)) begin
          errors++;
          $display("FAIL bubble_write%0d: ce=%b we=%b addr=%0d expected 1 %b %0d",
                   k, bram_ce, bram_we, bram_addr, 4'(1 << (k % 4)), 5 + k / 4);
        end
        k++;
      end else if (bram_ce !== 1'b0 || bram_we !== 4'b0) begin
        errors++; $display("FAIL bubble_gap%0d: ce=%b we=%b expected 0 0", c, bram_ce, bram_we);
      end
    end
    checks++;
    if (o_done !== 1'b1 || o_byte_cnt !== 11'd6 || o_short !== 1'b0) begin
      errors++; $display("FAIL bubble_done: done=%b cnt=%0d short=%b expected 1 6 0", o_done, o_byte_cnt, o_short);
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_count != 6 || mem[5] !== 32'h1312_1110 || mem[6] !== 32'hAABB_1514) begin
      errors++;
      $display("FAIL bubble_readback: writes=%0d w5=%h w6=%h expected 6 13121110 aabb1514",
               wr_count, mem[5], mem[6]);
    end
  endtask

  task automatic test_early_last;
    start_load(9'd20, 11'd10);
    wr_count = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hA0 + i); s_last = (i == 2);
      @(negedge clk);
    end
    s_last = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_short !== 1'b1 || o_byte_cnt !== 11'd3 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL early_done: done=%b short=%b cnt=%0d ready=%b expected 1 1 3 0",
               o_done, o_short, o_byte_cnt, s_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || wr_count != 3 || o_byte_cnt !== 11'd3) begin
      errors++;
      $display("FAIL early_after: ready=%b writes=%0d cnt=%0d expected 0 3 3", s_ready, wr_count, o_byte_cnt);
    end
    s_valid = 1'b0;
    checks++;
    if (mem[20][23:0] !== 24'hA2A1A0) begin
      errors++; $display("FAIL early_readback: got %h expected a2a1a0", mem[20][23:0]);
    end
  endtask

  task automatic test_wrap;
    start_load(9'd511, 11'd8);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h50 + i);
      @(negedge clk);
      checks++;
      if (bram_ce !== 1'b1 || bram_addr !== ((i < 4) ? 9'd511 : 9'd0)) begin
        errors++;
        $display("FAIL wrap_addr%0d: ce=%b addr=%0d expected 1 %0d", i, bram_ce, bram_addr, (i < 4) ? 511 : 0);
      end
    end
    s_valid = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_byte_cnt !== 11'd8) begin
      errors++; $display("FAIL wrap_done: done=%b cnt=%0d expected 1 8", o_done, o_byte_cnt);
    end
    @(negedge clk);
    checks++;
    if (mem[511] !== 32'h5352_5150 || mem[0] !== 32'h5756_5554) begin
      errors++; $display("FAIL wrap_readback: got %h %h expected 53525150 57565554", mem[511], mem[0]);
    end
  endtask

  task automatic test_zero;
    wr_count = 0;
    start_load(9'd40, 11'd0);
    checks++;
    if (o_done !== 1'b1 || o_byte_cnt !== 11'd0 || bram_ce !== 1'b0 || o_short !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b cnt=%0d ce=%b short=%b expected 1 0 0 0",
               o_done, o_byte_cnt, bram_ce, o_short);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || wr_count != 0) begin
      errors++; $display("FAIL zero_after: done=%b writes=%0d expected 0 0", o_done, wr_count);
    end
  endtask

  task automatic test_reset_mid;
    int done_seen;
    logic [63:0] outs;
    done_seen = 0;
    start_load(9'd100, 11'd8);
    wr_count = 0;
    // A start pulse mid-load with a different base/length must not be taken.
    s_valid = 1'b1; s_data = 8'hC0;
    i_start = 1'b1; i_base_addr = 9'd300; i_num_byte = 11'd2;
    @(negedge clk);
    i_start = 1'b0;
    s_data = 8'hC1;
    @(negedge clk);
    checks++;
    if (bram_addr !== 9'd100 || bram_we !== 4'b0010 || o_done !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: addr=%0d we=%b done=%b ready=%b expected 100 0010 0 1",
               bram_addr, bram_we, o_done, s_ready);
    end
    s_data = 8'hC2; reset = 1'b1;
    @(negedge clk);
    outs = {s_ready, o_busy, o_done, o_short, o_byte_cnt, bram_addr, bram_ce, bram_we, bram_d};
    checks++;
    if (outs !== 64'd0) begin
      errors++; $display("FAIL reset_mid_outs: got %h expected 0", outs);
    end
    reset = 1'b0; s_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_done) done_seen++;
    end
    checks++;
    if (done_seen != 0 || wr_count != 2) begin
      errors++; $display("FAIL reset_mid_nodone: dones=%0d writes=%0d expected 0 2", done_seen, wr_count);
    end
    start_load(9'd200, 11'd4);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hE0 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_byte_cnt !== 11'd4 || o_short !== 1'b0) begin
      errors++; $display("FAIL reload_done: done=%b cnt=%0d short=%b expected 1 4 0", o_done, o_byte_cnt, o_short);
    end
    @(negedge clk);
    checks++;
    if (mem[200] !== 32'hE3E2_E1E0) begin
      errors++; $display("FAIL reload_readback: got %h expected e3e2e1e0", mem[200]);
    end
  endtask

  task automatic test_we_onehot;
    checks++;
    if (multi_we != 0) begin
      errors++; $display("FAIL we_onehot: multi-bit patterns=%0d expected 0", multi_we);
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 32'h0;
    reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_byte = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_bubbles;
    test_early_last;
    test_wrap;
    test_zero;
    test_reset_mid;
    test_we_onehot;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
